dff_sync_chain: RTL and testbench
=================================

Name: dff_sync_chain

Overview:
- Parametrised successor to the single-bit register primitive.
- WIDTH-bit data passes through a STAGES-deep register chain with:
  - clock enable,
  - synchronous whole-chain load (preset),
  - a fill-tracking valid flag,
  - per-bit rise/fall edge detection on the output.
- Used wherever the design needs multi-cycle alignment of buses between clock-synced blocks, or clean edge events from a delayed bus.

Parameters:
- WIDTH, 8: data width in bits, ≥1.
- STAGES, 2: number of register stages from d to q, ≥1.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into every stage and into the edge-history register on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  shift enable.
- load  input  1  synchronous chain load; priority over en.
- load_val  input  WIDTH  value written to every stage when load=1.
- d  input  WIDTH  data into stage 0.
- q  output  WIDTH  last stage contents.
- q_valid  output  1  q holds data that has traversed the full chain, or load data.
- rise  output  WIDTH  per-bit 0→1 transition of q since the previous clock.
- fall  output  WIDTH  per-bit 1→0 transition of q since the previous clock.
- changed  output  1  OR-reduction of rise|fall.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - all stages = RESET_VAL, so q = RESET_VAL;
  - q_prev = RESET_VAL;
  - fill counter = 0, q_valid = 0, prev_valid = 0;
  - rise = fall = 0, changed = 0.
- Reset release: the first clock edge with reset=1 performs normal operation. No synchroniser is required inside this block.
- Per rising clk edge, priority order:
  - load=1:
    - every stage <= load_val, so q = load_val after this edge;
    - fill counter <= STAGES, so q_valid = 1 after this edge;
    - en and d are ignored.
  - else en=1:
    - stage0 <= d; stage k <= stage k-1 for k = 1..STAGES-1;
    - fill counter <= min(fill+1, STAGES), saturating.
  - else: all stages and fill counter hold.
- q_valid = (fill counter == STAGES). Counter width is clog2(STAGES+1).
- Latency: with en=1 continuously, d sampled at edge n appears on q after edge n+STAGES-1, i.e. STAGES edges counting the sampling edge. STAGES=1 degenerates to an enabled register with load.
- Edge history (updated every edge regardless of en/load):
  - q_prev <= q;
  - prev_valid <= q_valid.
- Edge outputs (combinational from registered state; no comb path from inputs):
  - edge_ok = q_valid & prev_valid.
  - rise = edge_ok ? (q & ~q_prev) : 0.
  - fall = edge_ok ? (~q & q_prev) : 0.
  - changed = |(rise | fall).
- Edge pulses last exactly one cycle per q change; holding en=0 yields rise = fall = 0 from the second held cycle on.
- Boundary conditions:
  - Load during fill:
    - q_valid asserts the edge after load;
    - edges are suppressed for one cycle, because prev_valid=0;
    - thereafter, comparisons against the load value are reported.
  - Load while valid: load_val vs prior q differences are reported as rise/fall one cycle after the load edge.
  - Reset mid-operation: immediate return to reset state; in-flight data is discarded.
  - load and en both high: load wins; no shift occurs.
  - Fill counter saturates; it never wraps.

Test Plan:
All scenarios use WIDTH=8, STAGES=3, RESET_VAL=8'hA5.
1. Reset:
   - Stimulus: drive reset=0 between clock edges.
   - Response: q=8'hA5, q_valid=0, rise=fall=0, changed=0 immediately, before any clk edge.
2. Fill and latency:
   - Stimulus: release reset, en=1, d=8'h3C held.
   - Response: q stays 8'hA5 for edges 1–2; q=8'h3C and q_valid=1 after edge 3; rise=fall=0 on that cycle (prev_valid=0).
3. Hold:
   - Stimulus: from a valid q=8'h3C, set en=0 and toggle d (8'hFF, 8'h00) for 5 cycles.
   - Response: q=8'h3C throughout; q_valid=1; rise=fall=0 after the first held cycle.
4. Load priority:
   - Stimulus: load=1, en=1, load_val=8'hF0, d=8'h0F for one edge.
   - Response: q=8'hF0 and q_valid=1 after that edge. Next cycle: rise=8'hC0, fall=8'h0C, changed=1 versus the previous 8'h3C.
5. Edge detect:
   - Stimulus: from steady valid q=8'h0F, apply en=1 with d=8'h1E.
   - Response: after 3 edges, q=8'h1E, rise=8'h10, fall=8'h01, changed=1 for exactly one cycle; then all 0.
6. Reset mid-fill:
   - Stimulus: after 2 enabled edges with d=8'h77, pulse reset=0.
   - Response: q=8'hA5 and q_valid=0 immediately. After release, 3 further enabled edges are again required before q=8'h77 and q_valid=1.

Source files
------------

// File: rtl/dff_sync_chain.sv
// dff_sync_chain: STAGES-deep WIDTH-bit enabled register chain with load, fill-tracking valid and per-bit edge detect
module dff_sync_chain #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  localparam int CW = $clog2(STAGES + 1);
  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] q_prev;
  logic [CW-1:0] fill;
  logic prev_valid;
  logic edge_ok;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) stage[k] <= RESET_VAL;
      fill <= '0;
      q_prev <= RESET_VAL;
      prev_valid <= 1'b0;
    end else begin
      q_prev <= q;
      prev_valid <= q_valid;
      if (load) begin
        for (int k = 0; k < STAGES; k++) stage[k] <= load_val;
        fill <= CW'(STAGES);
      end else if (en) begin
        stage[0] <= d;
        for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
        fill <= q_valid ? fill : fill + CW'(1);
      end
    end
  end
  // Edges are only meaningful once both the current and previous q were valid
  always_comb begin
    q = stage[STAGES-1];
    q_valid = (fill == CW'(STAGES));
    edge_ok = q_valid & prev_valid;
    rise = edge_ok ? (q & ~q_prev) : '0;
    fall = edge_ok ? (~q & q_prev) : '0;
    changed = |(rise | fall);
  end
endmodule

// File: tb/tb_dff_sync_chain.sv
// tb_dff_sync_chain: directed checks of fill latency, hold, load priority, edge detect and async reset
module tb_dff_sync_chain;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] d = 8'h00;
  logic [7:0] q, rise, fall;
  logic q_valid, changed;
  int checks = 0;
  int errors = 0;

  dff_sync_chain #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .d(d),
    .q(q), .q_valid(q_valid), .rise(rise), .fall(fall), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] eq, input logic ev,
                            input logic [7:0] er, input logic [7:0] ef);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".valid"}, 32'(q_valid), 32'(ev));
    check({tag, ".rise"}, 32'(rise), 32'(er));
    check({tag, ".fall"}, 32'(fall), 32'(ef));
    check({tag, ".changed"}, 32'(changed), 32'(|(er | ef)));
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 expect_out("reset", 8'hA5, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    en = 1'b1;
    d = 8'h3C;
    tick(); expect_out("fill1", 8'hA5, 1'b0, 8'h00, 8'h00);
    tick(); expect_out("fill2", 8'hA5, 1'b0, 8'h00, 8'h00);
    tick(); expect_out("fill3", 8'h3C, 1'b1, 8'h00, 8'h00);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = i[0] ? 8'h00 : 8'hFF;
      tick(); expect_out("hold", 8'h3C, 1'b1, 8'h00, 8'h00);
    end
    load = 1'b1; en = 1'b1; load_val = 8'hF0; d = 8'h0F;
    tick(); expect_out("load_pri", 8'hF0, 1'b1, 8'hC0, 8'h0C);
    load = 1'b0; en = 1'b0;
    tick(); expect_out("load_settle", 8'hF0, 1'b1, 8'h00, 8'h00);
    load = 1'b1; load_val = 8'h0F;
    tick(); expect_out("load_0f", 8'h0F, 1'b1, 8'h0F, 8'hF0);
    load = 1'b0;
    tick(); expect_out("steady_0f", 8'h0F, 1'b1, 8'h00, 8'h00);
    en = 1'b1; d = 8'h1E;
    tick(); expect_out("edge1", 8'h0F, 1'b1, 8'h00, 8'h00);
    tick(); expect_out("edge2", 8'h0F, 1'b1, 8'h00, 8'h00);
    tick(); expect_out("edge3", 8'h1E, 1'b1, 8'h10, 8'h01);
    tick(); expect_out("edge4", 8'h1E, 1'b1, 8'h00, 8'h00);
    d = 8'h77;
    tick();
    tick(); expect_out("midfill", 8'h1E, 1'b1, 8'h00, 8'h00);
    #1 reset = 1'b0;
    #1 expect_out("mid_reset", 8'hA5, 1'b0, 8'h00, 8'h00);
    #1 reset = 1'b1;
    tick(); expect_out("refill1", 8'hA5, 1'b0, 8'h00, 8'h00);
    tick(); expect_out("refill2", 8'hA5, 1'b0, 8'h00, 8'h00);
    tick(); expect_out("refill3", 8'h77, 1'b1, 8'h00, 8'h00);
    tick(); expect_out("refill4", 8'h77, 1'b1, 8'h00, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
